// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush and a saturating
// stall-cycle counter. Registers in_ready so there is no combinational path from out_ready.
module pipe_stage_skid #(
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          CTRL_W      = 18,
    parameter logic [CTRL_W-1:0]    BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              stat_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              skid_full,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [31:0]         main_pc,   skid_pc;
    logic [DATA_W-1:0]   main_data, skid_data;
    logic [CTRL_W-1:0]   main_ctrl, skid_ctrl;
    logic [15:0]         stall_q;

    logic accept;
    logic fire;

    always_comb begin
        accept = in_valid & in_ready_q;
        fire   = out_valid_q & out_ready;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_pc     <= '0;
            main_data   <= '0;
            main_ctrl   <= BUBBLE_CTRL;
            skid_pc     <= '0;
            skid_data   <= '0;
            skid_ctrl   <= BUBBLE_CTRL;
            stall_q     <= '0;
        end else begin
            if (stat_clr)
                stall_q <= '0;
            else if (out_valid_q && !out_ready && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;

            if (flush) begin
                state       <= EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
                main_pc     <= '0;
                main_data   <= '0;
                main_ctrl   <= BUBBLE_CTRL;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_pc     <= in_pc;
                            main_data   <= in_data;
                            main_ctrl   <= in_ctrl;
                            out_valid_q <= 1'b1;
                            state       <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (accept && fire) begin
                            main_pc   <= in_pc;
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end else if (accept) begin
                            // Downstream stalled: the one extra entry in flight lands in skid.
                            skid_pc    <= in_pc;
                            skid_data  <= in_data;
                            skid_ctrl  <= in_ctrl;
                            in_ready_q <= 1'b0;
                            state      <= FULL;
                        end else if (fire) begin
                            out_valid_q <= 1'b0;
                            state       <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (fire) begin
                            main_pc    <= skid_pc;
                            main_data  <= skid_data;
                            main_ctrl  <= skid_ctrl;
                            in_ready_q <= 1'b1;
                            state      <= BUSY;
                        end
                    end
                    default: begin
                        state       <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        in_ready     = in_ready_q;
        skid_full    = ~in_ready_q;
        out_valid    = out_valid_q;
        out_pc       = main_pc;
        out_data     = main_data;
        out_ctrl     = out_valid_q ? main_ctrl : BUBBLE_CTRL;
        stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: reset, streaming, backpressure,
// flush in FULL, counter saturation and asynchronous reset mid-stream.
module tb_pipe_stage_skid;

    localparam int unsigned       DATA_W = 32;
    localparam int unsigned       CTRL_W = 18;
    localparam logic [CTRL_W-1:0] BUBBLE = 18'h2A5A5;

    logic              clk = 1'b0;
    logic              clr;
    logic              flush;
    logic              stat_clr;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              skid_full;
    logic [15:0]       stall_cycles;

    int errors = 0;
    int checks = 0;

    pipe_stage_skid #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .BUBBLE_CTRL(BUBBLE)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .flush       (flush),
        .stat_clr    (stat_clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .skid_full   (skid_full),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] pc);
        return {pc[15:0], pc[15:0]} ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] pc);
        return pc[CTRL_W-1:0] ^ 18'h01234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_data  = data_of(pc);
        in_ctrl  = ctrl_of(pc);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_data"}, out_data, data_of(pc));
        check({tag, "_ctrl"}, {14'd0, out_ctrl}, {14'd0, ctrl_of(pc)});
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_skid"}, {31'd0, skid_full}, 32'd0);
        check({tag, "_pc"}, out_pc, 32'd0);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_ctrl"}, {14'd0, out_ctrl}, {14'd0, BUBBLE});
        check({tag, "_stall"}, {16'd0, stall_cycles}, 32'd0);
    endtask

    initial begin
        clr       = 1'b0;
        flush     = 1'b0;
        stat_clr  = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, 32'd0);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            offer($urandom_range(0, 1) == 1, $urandom);
            out_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        expect_reset("rst");

        #2 clr = 1'b1;
        offer(1'b0, 32'd0);
        out_ready = 1'b1;
        tick();

        // Streaming at full rate
        offer(1'b1, 32'd21); tick(); expect_out("s21", 32'd21);
        check("s21_ready", {31'd0, in_ready}, 32'd1);
        offer(1'b1, 32'd25); tick(); expect_out("s25", 32'd25);
        offer(1'b1, 32'd29); tick(); expect_out("s29", 32'd29);
        offer(1'b1, 32'd33); tick(); expect_out("s33", 32'd33);
        check("s33_skid", {31'd0, skid_full}, 32'd0);
        offer(1'b0, 32'd0);  tick();
        check("s_drain_valid", {31'd0, out_valid}, 32'd0);
        check("s_drain_ctrl", {14'd0, out_ctrl}, {14'd0, BUBBLE});
        check("s_drain_pc_hold", out_pc, 32'd33);

        // Backpressure into the skid entry
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        offer(1'b1, 32'd100); tick(); expect_out("b100", 32'd100);
        out_ready = 1'b0;
        offer(1'b1, 32'd104); tick();
        check("b_full_ready", {31'd0, in_ready}, 32'd0);
        check("b_full_skid", {31'd0, skid_full}, 32'd1);
        check("b_full_pc", out_pc, 32'd100);
        offer(1'b1, 32'd108); tick();
        check("b_hold_pc", out_pc, 32'd100);
        check("b_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick(); expect_out("b104", 32'd104);
        check("b104_ready", {31'd0, in_ready}, 32'd1);
        tick(); expect_out("b108", 32'd108);
        offer(1'b0, 32'd0); tick();
        check("b_end_valid", {31'd0, out_valid}, 32'd0);
        check("b_stall", {16'd0, stall_cycles}, 32'd2);

        // Flush while FULL, with a new entry offered the same cycle
        out_ready = 1'b0;
        offer(1'b1, 32'd200); tick();
        offer(1'b1, 32'd204); tick();
        check("f_full_skid", {31'd0, skid_full}, 32'd1);
        offer(1'b1, 32'd208); flush = 1'b1; tick(); flush = 1'b0;
        check("f_valid", {31'd0, out_valid}, 32'd0);
        check("f_ctrl", {14'd0, out_ctrl}, {14'd0, BUBBLE});
        check("f_ready", {31'd0, in_ready}, 32'd1);
        check("f_pc", out_pc, 32'd0);
        check("f_data", out_data, 32'd0);
        check("f_stall_kept", {16'd0, stall_cycles}, 32'd4);
        offer(1'b0, 32'd0); out_ready = 1'b1; tick();
        check("f_no208_valid", {31'd0, out_valid}, 32'd0);

        // Stall counter saturation and clear
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        check("sat_cleared", {16'd0, stall_cycles}, 32'd0);
        out_ready = 1'b0;
        offer(1'b1, 32'd300); tick();
        offer(1'b0, 32'd0);
        for (int i = 0; i < 65540; i++) tick();
        check("sat_value", {16'd0, stall_cycles}, 32'h0000FFFF);
        check("sat_pc", out_pc, 32'd300);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        check("sat_clr", {16'd0, stall_cycles}, 32'd0);
        tick();
        check("sat_recount", {16'd0, stall_cycles}, 32'd1);

        // Asynchronous reset in FULL, between clock edges
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        offer(1'b1, 32'd400); tick();
        offer(1'b1, 32'd404); tick();
        check("a_full_skid", {31'd0, skid_full}, 32'd1);
        offer(1'b0, 32'd0);
        #2 clr = 1'b0;
        #1 expect_reset("arst");
        #2 clr = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'd500); tick(); expect_out("a500", 32'd500);
        offer(1'b0, 32'd0); tick();
        check("a_end_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
